// File: rtl/pe_noc_interface.sv
// Network interface between one processing element and its HNoC port.
// Buffers TX and RX traffic, loops back self-addressed packets and tracks debug status.
module pe_noc_interface #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 3,
    parameter int PEAddr    = 0,
    parameter int FifoDepth = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [DataWidth-1:0]           i_tx_data,
    input  logic [AddrWidth-1:0]           i_tx_dest,
    input  logic                           i_tx_valid,
    output logic                           o_tx_ready,
    output logic [DataWidth+AddrWidth-1:0] o_noc_data,
    output logic                           o_noc_data_valid,
    input  logic                           i_noc_data_ready,
    input  logic [DataWidth+AddrWidth-1:0] i_noc_data,
    input  logic                           i_noc_data_valid,
    output logic                           o_noc_data_ready,
    output logic [DataWidth-1:0]           o_rx_data,
    output logic                           o_rx_valid,
    input  logic                           i_rx_ready,
    output logic [15:0]                    o_tx_count,
    output logic [15:0]                    o_rx_count,
    output logic                           o_misroute
);

    localparam int PW  = $clog2(FifoDepth);
    localparam int CW  = PW + 1;
    localparam int PKW = DataWidth + AddrWidth;

    localparam logic [PW-1:0]        PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]        PTR_ZERO = PW'(0);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]        CNT_FULL = CW'(FifoDepth);
    localparam logic [AddrWidth-1:0] PE_ADDR  = AddrWidth'(PEAddr);
    localparam logic [15:0]          STAT_MAX = 16'hFFFF;

    function automatic logic [CW-1:0] occ_next(input logic [CW-1:0] occ,
                                               input logic push, input logic pop);
        logic [CW-1:0] res;
        case ({push, pop})
            2'b10:   res = occ + CNT_ONE;
            2'b01:   res = occ - CNT_ONE;
            default: res = occ;
        endcase
        return res;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic inc);
        logic [15:0] res;
        if (inc && (cnt != STAT_MAX)) begin
            res = cnt + 16'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    logic [PKW-1:0]       tx_mem_r [FifoDepth];
    logic [PW-1:0]        tx_wr_r, tx_rd_r;
    logic [CW-1:0]        tx_cnt_r;
    logic [DataWidth-1:0] rx_mem_r [FifoDepth];
    logic [PW-1:0]        rx_wr_r, rx_rd_r;
    logic [CW-1:0]        rx_cnt_r;
    logic [15:0]          tx_count_r, rx_count_r;
    logic                 misroute_r;

    logic                 tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [PKW-1:0]       tx_head_s;
    logic                 head_loop_s, noc_valid_s;
    logic                 tx_push_s, tx_pop_s, noc_pop_s;
    logic                 noc_acc_s, noc_match_s, noc_wr_s, misroute_set_s, loop_wr_s;
    logic                 rx_push_s, rx_pop_s;
    logic [DataWidth-1:0] rx_push_data_s;

    assign tx_full_s   = (tx_cnt_r == CNT_FULL);
    assign tx_empty_s  = (tx_cnt_r == CNT_ZERO);
    assign rx_full_s   = (rx_cnt_r == CNT_FULL);
    assign rx_empty_s  = (rx_cnt_r == CNT_ZERO);
    assign tx_head_s   = tx_mem_r[tx_rd_r];
    assign head_loop_s = !tx_empty_s && (tx_head_s[PKW-1:DataWidth] == PE_ADDR);
    assign noc_valid_s = !tx_empty_s && !head_loop_s;

    // Ready flags depend only on stored occupancy, never on the far side's ready.
    assign tx_push_s      = i_tx_valid && !tx_full_s;
    assign noc_pop_s      = noc_valid_s && i_noc_data_ready;
    assign noc_acc_s      = i_noc_data_valid && !rx_full_s;
    assign noc_match_s    = (i_noc_data[PKW-1:DataWidth] == PE_ADDR);
    assign noc_wr_s       = noc_acc_s && noc_match_s;
    assign misroute_set_s = noc_acc_s && !noc_match_s;
    // NoC writes win the RX write port; loopback waits for a free cycle.
    assign loop_wr_s      = head_loop_s && !rx_full_s && !noc_wr_s;
    assign tx_pop_s       = noc_pop_s || loop_wr_s;
    assign rx_push_s      = noc_wr_s || loop_wr_s;
    assign rx_pop_s       = !rx_empty_s && i_rx_ready;

    // Select the payload source for the shared RX write port.
    always_comb begin
        rx_push_data_s = tx_head_s[DataWidth-1:0];
        if (noc_wr_s) begin
            rx_push_data_s = i_noc_data[DataWidth-1:0];
        end else begin
            rx_push_data_s = tx_head_s[DataWidth-1:0];
        end
    end

    // Output data is forced to zero whenever its valid is low.
    always_comb begin
        o_noc_data = {PKW{1'b0}};
        o_rx_data  = {DataWidth{1'b0}};
        if (noc_valid_s) begin
            o_noc_data = tx_head_s;
        end else begin
            o_noc_data = {PKW{1'b0}};
        end
        if (!rx_empty_s) begin
            o_rx_data = rx_mem_r[rx_rd_r];
        end else begin
            o_rx_data = {DataWidth{1'b0}};
        end
    end

    assign o_tx_ready       = !tx_full_s;
    assign o_noc_data_valid = noc_valid_s;
    assign o_noc_data_ready = !rx_full_s;
    assign o_rx_valid       = !rx_empty_s;
    assign o_tx_count       = tx_count_r;
    assign o_rx_count       = rx_count_r;
    assign o_misroute       = misroute_r;

    // TX FIFO storage, pointers and occupancy.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_wr_r  <= PTR_ZERO;
            tx_rd_r  <= PTR_ZERO;
            tx_cnt_r <= CNT_ZERO;
            for (int i = 0; i < FifoDepth; i++) begin
                tx_mem_r[i] <= {PKW{1'b0}};
            end
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_wr_r] <= {i_tx_dest, i_tx_data};
                tx_wr_r           <= tx_wr_r + PTR_ONE;
            end
            if (tx_pop_s) begin
                tx_rd_r <= tx_rd_r + PTR_ONE;
            end
            tx_cnt_r <= occ_next(tx_cnt_r, tx_push_s, tx_pop_s);
        end
    end

    // RX FIFO storage, pointers and occupancy.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_wr_r  <= PTR_ZERO;
            rx_rd_r  <= PTR_ZERO;
            rx_cnt_r <= CNT_ZERO;
            for (int i = 0; i < FifoDepth; i++) begin
                rx_mem_r[i] <= {DataWidth{1'b0}};
            end
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_wr_r] <= rx_push_data_s;
                rx_wr_r           <= rx_wr_r + PTR_ONE;
            end
            if (rx_pop_s) begin
                rx_rd_r <= rx_rd_r + PTR_ONE;
            end
            rx_cnt_r <= occ_next(rx_cnt_r, rx_push_s, rx_pop_s);
        end
    end

    // Saturating traffic counters and sticky misroute flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_count_r <= 16'd0;
            rx_count_r <= 16'd0;
            misroute_r <= 1'b0;
        end else begin
            tx_count_r <= sat_inc(tx_count_r, tx_pop_s);
            rx_count_r <= sat_inc(rx_count_r, rx_push_s);
            misroute_r <= misroute_r | misroute_set_s;
        end
    end

endmodule

// File: tb/tb_pe_noc_interface.sv
// Directed bench for pe_noc_interface (DW=32, AW=3, PEAddr=2, depth 4).
module tb_pe_noc_interface;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_tx_data;
    logic [2:0]  i_tx_dest;
    logic        i_tx_valid;
    logic        o_tx_ready;
    logic [34:0] o_noc_data;
    logic        o_noc_data_valid;
    logic        i_noc_data_ready;
    logic [34:0] i_noc_data;
    logic        i_noc_data_valid;
    logic        o_noc_data_ready;
    logic [31:0] o_rx_data;
    logic        o_rx_valid;
    logic        i_rx_ready;
    logic [15:0] o_tx_count;
    logic [15:0] o_rx_count;
    logic        o_misroute;

    int total = 0;
    int bad   = 0;

    pe_noc_interface #(
        .DataWidth(32), .AddrWidth(3), .PEAddr(2), .FifoDepth(4)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_tx_data(i_tx_data), .i_tx_dest(i_tx_dest), .i_tx_valid(i_tx_valid),
        .o_tx_ready(o_tx_ready),
        .o_noc_data(o_noc_data), .o_noc_data_valid(o_noc_data_valid),
        .i_noc_data_ready(i_noc_data_ready),
        .i_noc_data(i_noc_data), .i_noc_data_valid(i_noc_data_valid),
        .o_noc_data_ready(o_noc_data_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
        .o_tx_count(o_tx_count), .o_rx_count(o_rx_count), .o_misroute(o_misroute)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tx_ready"},  64'(o_tx_ready), 64'd1);
        chk({tag, "_noc_ready"}, 64'(o_noc_data_ready), 64'd1);
        chk({tag, "_noc_valid"}, 64'(o_noc_data_valid), 64'd0);
        chk({tag, "_rx_valid"},  64'(o_rx_valid), 64'd0);
        chk({tag, "_noc_data"},  64'(o_noc_data), 64'd0);
        chk({tag, "_rx_data"},   64'(o_rx_data), 64'd0);
        chk({tag, "_tx_count"},  64'(o_tx_count), 64'd0);
        chk({tag, "_rx_count"},  64'(o_rx_count), 64'd0);
        chk({tag, "_misroute"},  64'(o_misroute), 64'd0);
    endtask

    initial begin
        logic [31:0] exp_d;
        i_reset = 1'b1;
        i_tx_data = 32'h0; i_tx_dest = 3'd0; i_tx_valid = 1'b0;
        i_noc_data_ready = 1'b0; i_noc_data = 35'h0; i_noc_data_valid = 1'b0;
        i_rx_ready = 1'b0;
        @(negedge i_clk);
        chk_reset("rst");
        i_reset = 1'b0;
        step();

        // Single NoC-bound packet
        i_noc_data_ready = 1'b1;
        i_tx_dest = 3'd5; i_tx_data = 32'hDEADBEEF; i_tx_valid = 1'b1;
        step();
        i_tx_valid = 1'b0;
        chk("t1_valid", 64'(o_noc_data_valid), 64'd1);
        chk("t1_data", 64'(o_noc_data), 64'h5DEADBEEF);
        chk("t1_cnt_before", 64'(o_tx_count), 64'd0);
        step();
        chk("t1_cnt_after", 64'(o_tx_count), 64'd1);
        chk("t1_valid_after", 64'(o_noc_data_valid), 64'd0);

        // TX backpressure: four fill the FIFO, fifth is held off
        i_noc_data_ready = 1'b0;
        i_tx_dest = 3'd1;
        for (int i = 0; i < 4; i++) begin
            i_tx_data = 32'h100 + 32'(i); i_tx_valid = 1'b1;
            chk("t2_ready_fill", 64'(o_tx_ready), 64'd1);
            step();
        end
        chk("t2_ready_full", 64'(o_tx_ready), 64'd0);
        i_tx_data = 32'h104;
        step();
        chk("t2_ready_held", 64'(o_tx_ready), 64'd0);
        chk("t2_cnt_held", 64'(o_tx_count), 64'd1);
        i_tx_valid = 1'b0;
        i_noc_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_order_valid", 64'(o_noc_data_valid), 64'd1);
            chk("t2_order_data", 64'(o_noc_data), {29'd0, 3'd1, 32'h100 + 32'(i)});
            step();
        end
        chk("t2_drained", 64'(o_noc_data_valid), 64'd0);
        chk("t2_cnt", 64'(o_tx_count), 64'd5);

        // RX delivery and misroute
        i_noc_data = {3'd2, 32'h12345678}; i_noc_data_valid = 1'b1;
        chk("t3_noc_ready", 64'(o_noc_data_ready), 64'd1);
        step();
        i_noc_data_valid = 1'b0;
        chk("t3_rx_valid", 64'(o_rx_valid), 64'd1);
        chk("t3_rx_data", 64'(o_rx_data), 64'h12345678);
        chk("t3_rx_cnt", 64'(o_rx_count), 64'd1);
        i_noc_data = {3'd6, 32'h1}; i_noc_data_valid = 1'b1;
        step();
        i_noc_data_valid = 1'b0;
        chk("t3_misroute", 64'(o_misroute), 64'd1);
        chk("t3_rx_cnt_drop", 64'(o_rx_count), 64'd1);
        chk("t3_head_kept", 64'(o_rx_data), 64'h12345678);
        i_rx_ready = 1'b1;
        step();
        i_rx_ready = 1'b0;
        chk("t3_rx_empty", 64'(o_rx_valid), 64'd0);
        step();
        chk("t3_misroute_sticky", 64'(o_misroute), 64'd1);

        // Loopback contending with a NoC delivery
        i_tx_dest = 3'd2; i_tx_data = 32'hA5; i_tx_valid = 1'b1;
        step();
        i_tx_valid = 1'b0;
        i_noc_data = {3'd2, 32'hB6}; i_noc_data_valid = 1'b1;
        chk("t4_loop_no_noc", 64'(o_noc_data_valid), 64'd0);
        step();
        i_noc_data_valid = 1'b0;
        chk("t4_first_b6", 64'(o_rx_data), 64'hB6);
        chk("t4_rx_cnt_mid", 64'(o_rx_count), 64'd2);
        chk("t4_tx_cnt_mid", 64'(o_tx_count), 64'd5);
        chk("t4_loop_no_noc2", 64'(o_noc_data_valid), 64'd0);
        step();
        chk("t4_tx_cnt", 64'(o_tx_count), 64'd6);
        chk("t4_rx_cnt", 64'(o_rx_count), 64'd3);
        i_rx_ready = 1'b1;
        step();
        chk("t4_second_a5", 64'(o_rx_data), 64'hA5);
        chk("t4_second_valid", 64'(o_rx_valid), 64'd1);
        step();
        i_rx_ready = 1'b0;
        chk("t4_rx_empty", 64'(o_rx_valid), 64'd0);

        // RX full: fifth packet waits for a pop
        for (int i = 0; i < 4; i++) begin
            i_noc_data = {3'd2, 32'h10 + 32'(i)}; i_noc_data_valid = 1'b1;
            step();
        end
        chk("t5_full_ready", 64'(o_noc_data_ready), 64'd0);
        chk("t5_full_cnt", 64'(o_rx_count), 64'd7);
        i_noc_data = {3'd2, 32'h55};
        step();
        chk("t5_held_ready", 64'(o_noc_data_ready), 64'd0);
        chk("t5_held_cnt", 64'(o_rx_count), 64'd7);
        chk("t5_head", 64'(o_rx_data), 64'h10);
        i_rx_ready = 1'b1;
        step();
        i_rx_ready = 1'b0;
        chk("t5_space_ready", 64'(o_noc_data_ready), 64'd1);
        chk("t5_space_cnt", 64'(o_rx_count), 64'd7);
        step();
        i_noc_data_valid = 1'b0;
        chk("t5_fifth_cnt", 64'(o_rx_count), 64'd8);
        chk("t5_refull", 64'(o_noc_data_ready), 64'd0);
        i_rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_d = (i < 3) ? 32'h11 + 32'(i) : 32'h55;
            chk("t5_drain", 64'(o_rx_data), 64'(exp_d));
            step();
        end
        i_rx_ready = 1'b0;
        chk("t5_empty", 64'(o_rx_valid), 64'd0);

        // Asynchronous reset with both FIFOs partly full
        i_noc_data_ready = 1'b0;
        i_tx_dest = 3'd4; i_tx_data = 32'h70; i_tx_valid = 1'b1;
        i_noc_data = {3'd2, 32'h80}; i_noc_data_valid = 1'b1;
        step();
        i_tx_data = 32'h71; i_noc_data = {3'd2, 32'h81};
        step();
        i_tx_valid = 1'b0; i_noc_data_valid = 1'b0;
        chk("t6_pre_noc_valid", 64'(o_noc_data_valid), 64'd1);
        chk("t6_pre_rx_valid", 64'(o_rx_valid), 64'd1);
        #2 i_reset = 1'b1;
        #1 chk_reset("t6_async");
        @(negedge i_clk);
        i_reset = 1'b0;
        i_noc_data_ready = 1'b1;
        i_tx_dest = 3'd3; i_tx_data = 32'hCAFE; i_tx_valid = 1'b1;
        step();
        i_tx_valid = 1'b0;
        chk("t6_fresh_data", 64'(o_noc_data), {29'd0, 3'd3, 32'hCAFE});
        step();
        chk("t6_fresh_cnt", 64'(o_tx_count), 64'd1);

        // RX counter saturation
        i_rx_ready = 1'b1;
        i_noc_data = {3'd2, 32'h9}; i_noc_data_valid = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            step();
        end
        chk("t7_cnt_fffe", 64'(o_rx_count), 64'hFFFE);
        step();
        chk("t7_cnt_ffff", 64'(o_rx_count), 64'hFFFF);
        step();
        step();
        chk("t7_cnt_sat", 64'(o_rx_count), 64'hFFFF);
        i_noc_data_valid = 1'b0;
        i_rx_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
